// File: rtl/av_sata_rate_ctrl.sv
// ---------------------------------------------------------------------------
// av_sata_rate_ctrl
//
// Changes the SATA line rate (Gen1/Gen2/Gen3) of an ArriaV transceiver
// channel. The block acts as an Avalon-MM master on the reconfiguration
// controller's management port. It streams a fixed MIF register sequence,
// polls the controller's busy bit after each start command, and holds the
// transceiver in reset for the whole operation.
//
// Ports
//   reset            in   synchronous, active-high reset
//   clk              in   reconfig_clk domain clock
//   rate_req         in   request strobe, accepted only while idle
//   rate_gen         in   requested generation (1..3, 0 is invalid)
//   rate_busy        out  request in progress
//   rate_done        out  one-cycle pulse on successful completion
//   rate_error       out  sticky error, cleared by the next accepted request
//   cur_gen          out  currently configured generation
//   xcvr_reset       out  transceiver hold-reset
//   reconfig_busy    in   busy flag from the reconfiguration core
//   mgmt_address     out  Avalon-MM address
//   mgmt_write       out  Avalon-MM write
//   mgmt_writedata   out  Avalon-MM write data
//   mgmt_read        out  Avalon-MM read
//   mgmt_readdata    in   Avalon-MM read data (bit 8 = controller busy)
//   mgmt_waitrequest in   Avalon-MM wait request
// ---------------------------------------------------------------------------
module av_sata_rate_ctrl #(
  parameter int unsigned CHANNEL    = 0,
  parameter logic [31:0] GEN1_MIF   = 32'h000,
  parameter logic [31:0] GEN2_MIF   = 32'h100,
  parameter logic [31:0] GEN3_MIF   = 32'h200,
  parameter logic [1:0]  INIT_GEN   = 2'd2,
  parameter int unsigned POLL_LIMIT = 1024,
  parameter int unsigned RESET_HOLD = 16
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        rate_req,
  input  logic [1:0]  rate_gen,
  output logic        rate_busy,
  output logic        rate_done,
  output logic        rate_error,
  output logic [1:0]  cur_gen,
  output logic        xcvr_reset,
  input  logic        reconfig_busy,
  output logic [6:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_read,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CHECK     = 4'd1;
  localparam logic [3:0] S_WAIT_FREE = 4'd2;
  localparam logic [3:0] S_WRITE     = 4'd3;
  localparam logic [3:0] S_POLL_RD   = 4'd4;
  localparam logic [3:0] S_POLL_CHK  = 4'd5;
  localparam logic [3:0] S_HOLD      = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_ERROR     = 4'd8;

  // Reconfiguration controller register map (MIF streaming)
  localparam logic [6:0] A_CHANNEL = 7'h38;
  localparam logic [6:0] A_CTRL    = 7'h3A;
  localparam logic [6:0] A_OFFSET  = 7'h3B;
  localparam logic [6:0] A_DATA    = 7'h3C;

  localparam int unsigned PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam int unsigned HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

  logic [3:0]    state;
  logic [1:0]    gen_lat;
  logic [2:0]    step;
  logic          phase_b;
  logic          rd_busy;
  logic [PW-1:0] poll_cnt;
  logic [HW-1:0] hold_cnt;

  logic [31:0]   mif_base;
  logic [6:0]    step_addr;
  logic [31:0]   step_data;

  // Only the busy bit of the status register matters here.
  logic          readdata_unused;
  assign readdata_unused = ^{mgmt_readdata[31:9], mgmt_readdata[7:0]};

  always_comb begin
    mif_base = GEN1_MIF;
    case (gen_lat)
      2'd2:    mif_base = GEN2_MIF;
      2'd3:    mif_base = GEN3_MIF;
      default: mif_base = GEN1_MIF;
    endcase
  end

  // Register sequence: steps 0-4 load the MIF base and start streaming,
  // steps 5-7 restart from offset 1 after the first busy poll clears.
  always_comb begin
    step_addr = A_CTRL;
    step_data = '0;
    case (step)
      3'd0: begin step_addr = A_CHANNEL; step_data = 32'(CHANNEL); end
      3'd1: begin step_addr = A_CTRL;    step_data = 32'd0;        end
      3'd2: begin step_addr = A_OFFSET;  step_data = 32'd0;        end
      3'd3: begin step_addr = A_DATA;    step_data = mif_base;     end
      3'd4: begin step_addr = A_CTRL;    step_data = 32'd1;        end
      3'd5: begin step_addr = A_OFFSET;  step_data = 32'd1;        end
      3'd6: begin step_addr = A_DATA;    step_data = 32'd1;        end
      default: begin step_addr = A_CTRL; step_data = 32'd1;        end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      gen_lat        <= '0;
      step           <= '0;
      phase_b        <= 1'b0;
      rd_busy        <= 1'b0;
      poll_cnt       <= '0;
      hold_cnt       <= '0;
      rate_busy      <= 1'b0;
      rate_done      <= 1'b0;
      rate_error     <= 1'b0;
      cur_gen        <= INIT_GEN;
      xcvr_reset     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_write     <= 1'b0;
      mgmt_writedata <= '0;
      mgmt_read      <= 1'b0;
    end else begin
      rate_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rate_req) begin
            gen_lat    <= rate_gen;
            rate_error <= 1'b0;
            rate_busy  <= 1'b1;
            state      <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (gen_lat == 2'd0) begin
            state <= S_ERROR;
          end else if (gen_lat == cur_gen) begin
            state <= S_DONE;
          end else begin
            xcvr_reset <= 1'b1;
            state      <= S_WAIT_FREE;
          end
        end

        S_WAIT_FREE: begin
          if (!reconfig_busy) begin
            step     <= 3'd0;
            phase_b  <= 1'b0;
            poll_cnt <= '0;
            state    <= S_WRITE;
          end
        end

        // Command is raised on one edge and dropped on its completing edge,
        // so the next step's command always follows at least one idle cycle.
        S_WRITE: begin
          if (!mgmt_write) begin
            mgmt_write     <= 1'b1;
            mgmt_address   <= step_addr;
            mgmt_writedata <= step_data;
          end else if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            step       <= step + 3'd1;
            if (step == 3'd4) begin
              phase_b  <= 1'b0;
              poll_cnt <= '0;
              state    <= S_POLL_RD;
            end else if (step == 3'd7) begin
              phase_b  <= 1'b1;
              poll_cnt <= '0;
              state    <= S_POLL_RD;
            end
          end
        end

        S_POLL_RD: begin
          if (!mgmt_read) begin
            mgmt_read    <= 1'b1;
            mgmt_address <= A_CTRL;
          end else if (!mgmt_waitrequest) begin
            mgmt_read <= 1'b0;
            rd_busy   <= mgmt_readdata[8];
            state     <= S_POLL_CHK;
          end
        end

        // This state doubles as the idle cycle between consecutive reads.
        S_POLL_CHK: begin
          if (rd_busy) begin
            if (poll_cnt == POLL_LAST) begin
              state <= S_ERROR;
            end else begin
              poll_cnt <= poll_cnt + PW'(1);
              state    <= S_POLL_RD;
            end
          end else if (phase_b) begin
            hold_cnt <= '0;
            state    <= S_HOLD;
          end else begin
            state <= S_WRITE;
          end
        end

        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= S_DONE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        S_DONE: begin
          xcvr_reset <= 1'b0;
          cur_gen    <= gen_lat;
          rate_done  <= 1'b1;
          rate_busy  <= 1'b0;
          state      <= S_IDLE;
        end

        S_ERROR: begin
          xcvr_reset <= 1'b0;
          rate_error <= 1'b1;
          rate_busy  <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_av_sata_rate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_av_sata_rate_ctrl
//
// Directed bench for av_sata_rate_ctrl. A small Avalon-MM slave model
// answers the management port (optional random wait states, a programmable
// number of busy status reads) and logs every completed transfer. A table of
// request vectors is applied in order, followed by hand-written sequences for
// poll timeout, reconfig_busy gating and reset during a poll.
// ---------------------------------------------------------------------------
module tb_av_sata_rate_ctrl;

  localparam int          CHANNEL_P  = 3;
  localparam int          POLL_LIM   = 1024;
  localparam int          HOLD_CYC   = 16;
  localparam logic [1:0]  INIT_G     = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        rate_req;
  logic [1:0]  rate_gen;
  logic        rate_busy;
  logic        rate_done;
  logic        rate_error;
  logic [1:0]  cur_gen;
  logic        xcvr_reset;
  logic        reconfig_busy;
  logic [6:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;

  always #5 clk = ~clk;

  av_sata_rate_ctrl #(
    .CHANNEL    (CHANNEL_P),
    .GEN1_MIF   (32'h000),
    .GEN2_MIF   (32'h100),
    .GEN3_MIF   (32'h200),
    .INIT_GEN   (INIT_G),
    .POLL_LIMIT (POLL_LIM),
    .RESET_HOLD (HOLD_CYC)
  ) dut (
    .reset            (reset),
    .clk              (clk),
    .rate_req         (rate_req),
    .rate_gen         (rate_gen),
    .rate_busy        (rate_busy),
    .rate_done        (rate_done),
    .rate_error       (rate_error),
    .cur_gen          (cur_gen),
    .xcvr_reset       (xcvr_reset),
    .reconfig_busy    (reconfig_busy),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_read        (mgmt_read),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- Avalon slave model and transfer monitor ----------------
  bit          stall_en     = 1'b0;
  bit          busy_forever = 1'b0;
  int          busy_left    = 0;
  int          stall_left   = 0;
  bit          in_xfer      = 1'b0;

  int          n_wr = 0;
  int          n_rd = 0;
  logic [6:0]  wr_addr [16];
  logic [31:0] wr_data [16];
  int          proto_err = 0;
  int          xcvr_err  = 0;
  bit          xcvr_seen = 1'b0;

  bit          prev_stall = 1'b0;
  bit          prev_done  = 1'b0;
  logic [6:0]  p_addr;
  logic [31:0] p_data;
  logic        p_wr, p_rd;

  initial begin
    mgmt_waitrequest = 1'b0;
    mgmt_readdata    = 32'hFFFF_FEFF;
  end

  // Wait states and read data change only on the falling edge so they are
  // stable when the DUT samples them.
  always @(negedge clk) begin
    if ((mgmt_write || mgmt_read) && stall_en) begin
      if (!in_xfer) begin
        in_xfer    = 1'b1;
        stall_left = $urandom_range(1, 5);
      end
      if (stall_left > 0) begin
        mgmt_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mgmt_waitrequest = 1'b0;
      end
    end else begin
      mgmt_waitrequest = 1'b0;
      in_xfer          = 1'b0;
    end
    // Non-busy status carries noise in every other bit.
    mgmt_readdata = (busy_forever || busy_left > 0) ? 32'h0000_0100 : 32'hFFFF_FEFF;
  end

  always @(posedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (xcvr_reset) xcvr_seen = 1'b1;
      if (mgmt_write && mgmt_read) proto_err++;
      if (prev_stall && (mgmt_address !== p_addr || mgmt_writedata !== p_data ||
                         mgmt_write !== p_wr || mgmt_read !== p_rd)) proto_err++;
      if (prev_done && (mgmt_write || mgmt_read)) proto_err++;
      if ((mgmt_write || mgmt_read) && !mgmt_waitrequest) begin
        if (!xcvr_reset) xcvr_err++;
        if (mgmt_write) begin
          if (n_wr < 16) begin
            wr_addr[n_wr] = mgmt_address;
            wr_data[n_wr] = mgmt_writedata;
          end
          n_wr++;
        end else begin
          if (mgmt_address !== 7'h3A) proto_err++;
          n_rd++;
          if (busy_left > 0) busy_left--;
        end
      end
      prev_stall = (mgmt_write || mgmt_read) && mgmt_waitrequest;
      prev_done  = (mgmt_write || mgmt_read) && !mgmt_waitrequest;
      p_addr     = mgmt_address;
      p_data     = mgmt_writedata;
      p_wr       = mgmt_write;
      p_rd       = mgmt_read;
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_log();
    n_wr      = 0;
    n_rd      = 0;
    xcvr_seen = 1'b0;
  endtask

  task automatic issue(input logic [1:0] g);
    @(negedge clk);
    rate_gen = g;
    rate_req = 1'b1;
    @(negedge clk);
    rate_req = 1'b0;
  endtask

  // Cycles counted from the edge that accepted the request.
  task automatic wait_end(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(rate_done || rate_error) && n < limit);
  endtask

  task automatic check_sequence(input string tag, input logic [31:0] mif);
    logic [6:0]  ea [8];
    logic [31:0] ed [8];
    ea = '{7'h38, 7'h3A, 7'h3B, 7'h3C, 7'h3A, 7'h3B, 7'h3C, 7'h3A};
    ed = '{32'(CHANNEL_P), 32'd0, 32'd0, mif, 32'd1, 32'd1, 32'd1, 32'd1};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_addr[i]), 32'(ea[i]));
      check($sformatf("%s_wr%0d_data", tag, i), wr_data[i], ed[i]);
    end
  endtask

  typedef struct {
    logic [1:0]  gen;
    int          busy;
    bit          stall;
    bit          exp_err;
    logic [1:0]  exp_gen;
    int          exp_wr;
    int          exp_rd;
    logic [31:0] exp_mif;
    int          exp_lat;   // -1: not checked (random stalls)
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    int snap_wr, snap_rd;

    // full path: 8 writes x 2 + 2 polls x 3 + HOLD + 3 = 41 cycles
    vecs[0] = '{2'd1, 0, 1'b0, 1'b0, 2'd1, 8, 2, 32'h000, 41};
    vecs[1] = '{2'd2, 2, 1'b0, 1'b0, 2'd2, 8, 4, 32'h100, 47};
    vecs[2] = '{2'd2, 0, 1'b0, 1'b0, 2'd2, 0, 0, 32'h000, 2};
    vecs[3] = '{2'd0, 0, 1'b0, 1'b1, 2'd2, 0, 0, 32'h000, 2};
    vecs[4] = '{2'd3, 1, 1'b1, 1'b0, 2'd3, 8, 3, 32'h200, -1};
    vecs[5] = '{2'd1, 0, 1'b0, 1'b0, 2'd1, 8, 2, 32'h000, 41};

    reset         = 1'b1;
    rate_req      = 1'b0;
    rate_gen      = 2'd0;
    reconfig_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(rate_busy), 0);
    check("rst_done",  32'(rate_done), 0);
    check("rst_err",   32'(rate_error), 0);
    check("rst_gen",   32'(cur_gen), 32'(INIT_G));
    check("rst_xcvr",  32'(xcvr_reset), 0);
    check("rst_wr",    32'(mgmt_write), 0);
    check("rst_rd",    32'(mgmt_read), 0);
    check("rst_addr",  32'(mgmt_address), 0);
    check("rst_wdata", mgmt_writedata, 0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table-driven requests ----------------
    for (int v = 0; v < 6; v++) begin
      clear_log();
      busy_left    = vecs[v].busy;
      busy_forever = 1'b0;
      stall_en     = vecs[v].stall;
      issue(vecs[v].gen);
      check($sformatf("v%0d_busy_flag", v), 32'(rate_busy), 1);
      wait_end(5000, n);
      if (vecs[v].exp_lat >= 0) check($sformatf("v%0d_latency", v), n, vecs[v].exp_lat);
      check($sformatf("v%0d_done", v),  32'(rate_done),  32'(!vecs[v].exp_err));
      check($sformatf("v%0d_error", v), 32'(rate_error), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_cur_gen", v), 32'(cur_gen), 32'(vecs[v].exp_gen));
      check($sformatf("v%0d_writes", v), n_wr, vecs[v].exp_wr);
      check($sformatf("v%0d_reads", v),  n_rd, vecs[v].exp_rd);
      check($sformatf("v%0d_xcvr_used", v), 32'(xcvr_seen), 32'(vecs[v].exp_wr > 0));
      check($sformatf("v%0d_xcvr_end", v), 32'(xcvr_reset), 0);
      check($sformatf("v%0d_busy_end", v), 32'(rate_busy), 0);
      if (vecs[v].exp_wr == 8) check_sequence($sformatf("v%0d", v), vecs[v].exp_mif);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", v), 32'(rate_done), 0);
      check($sformatf("v%0d_err_sticky", v), 32'(rate_error), 32'(vecs[v].exp_err));
    end
    stall_en = 1'b0;
    check("proto_after_table", proto_err, 0);
    check("xcvr_after_table",  xcvr_err, 0);

    // ---------------- busy never clears: poll timeout ----------------
    clear_log();
    busy_forever = 1'b1;
    issue(2'd3);
    wait_end(20000, n);
    check("to_error",   32'(rate_error), 1);
    check("to_done",    32'(rate_done), 0);
    check("to_reads",   n_rd, POLL_LIM);
    check("to_writes",  n_wr, 5);
    check("to_xcvr",    32'(xcvr_reset), 0);
    check("to_rd_low",  32'(mgmt_read), 0);
    check("to_cur_gen", 32'(cur_gen), 1);
    check("to_busy",    32'(rate_busy), 0);
    busy_forever = 1'b0;

    // ---------------- reconfig_busy gating ----------------
    clear_log();
    @(negedge clk);
    reconfig_busy = 1'b1;
    issue(2'd2);
    repeat (50) begin
      @(posedge clk);
      #1;
    end
    check("rb_no_xfer",  n_wr + n_rd, 0);
    check("rb_no_cmd",   32'(mgmt_write | mgmt_read), 0);
    check("rb_xcvr",     32'(xcvr_reset), 1);
    check("rb_err_clr",  32'(rate_error), 0);
    check("rb_busy",     32'(rate_busy), 1);
    @(negedge clk);
    reconfig_busy = 1'b0;
    wait_end(500, n);
    check("rb_done",    32'(rate_done), 1);
    check("rb_cur_gen", 32'(cur_gen), 2);
    check("rb_writes",  n_wr, 8);
    check("rb_reads",   n_rd, 2);

    // ---------------- reset during a poll ----------------
    clear_log();
    busy_forever = 1'b1;
    issue(2'd1);
    for (int i = 0; i < 300 && n_rd < 3; i++) @(negedge clk);
    check("mp_reached_poll", 32'(n_rd >= 3), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mp_busy",  32'(rate_busy), 0);
    check("mp_done",  32'(rate_done), 0);
    check("mp_err",   32'(rate_error), 0);
    check("mp_gen",   32'(cur_gen), 32'(INIT_G));
    check("mp_xcvr",  32'(xcvr_reset), 0);
    check("mp_wr",    32'(mgmt_write), 0);
    check("mp_rd",    32'(mgmt_read), 0);
    check("mp_addr",  32'(mgmt_address), 0);
    check("mp_wdata", mgmt_writedata, 0);
    @(negedge clk);
    reset   = 1'b0;
    snap_wr = n_wr;
    snap_rd = n_rd;
    repeat (10) @(negedge clk);
    check("mp_no_more_wr", n_wr, snap_wr);
    check("mp_no_more_rd", n_rd, snap_rd);
    check("mp_idle_busy",  32'(rate_busy), 0);
    busy_forever = 1'b0;

    check("proto_final", proto_err, 0);
    check("xcvr_final",  xcvr_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
